// File: rtl/edge_event_pkg.sv
// Shared types and helpers for the edge/event input conditioner.
package edge_event_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Debounce counter width: must hold values up to DEBOUNCE_CYCLES.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain, debounce counter, stable level and
// single-cycle rising/falling pulse registers.
module debounce_channel
  import edge_event_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic risingedge,
  output logic fallingedge
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    sync_d  = {sync_q[SYNC_STAGES-2:0], in};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any sample matching the current level restarts the count (glitch rejection).
    if (sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync;
        rise_d  = sync;
        fall_d  = ~sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level       = level_q;
  assign risingedge  = rise_q;
  assign fallingedge = fall_q;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel input conditioner: per-channel debounce/edge detection plus
// mode-qualified sticky event flags and a combined interrupt.
module edge_event_unit
  import edge_event_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic                 clk50m,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*WIDTH-1:0]   edge_mode,
  input  logic [WIDTH-1:0]     event_clr,
  output logic [WIDTH-1:0]     level,
  output logic [WIDTH-1:0]     risingedge,
  output logic [WIDTH-1:0]     fallingedge,
  output logic [WIDTH-1:0]     event_pending,
  output logic                 irq
);

  logic [WIDTH-1:0] qual;
  logic [WIDTH-1:0] pend_q, pend_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_ch (
      .clk50m      (clk50m),
      .rst_n       (rst_n),
      .in          (in[i]),
      .level       (level[i]),
      .risingedge  (risingedge[i]),
      .fallingedge (fallingedge[i])
    );
  end

  always_comb begin
    qual = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (edge_mode_t'(edge_mode[2*i +: 2]))
        EDGE_RISE: qual[i] = risingedge[i];
        EDGE_FALL: qual[i] = fallingedge[i];
        EDGE_BOTH: qual[i] = risingedge[i] | fallingedge[i];
        default:   qual[i] = 1'b0;
      endcase
    end
    // A set in the same cycle as a clear wins; mode only gates new sets.
    pend_d = qual | (pend_q & ~event_clr);
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign event_pending = pend_q;
  assign irq           = |pend_q;

endmodule

// File: doc/edge_event_unit.md
# edge_event_unit

Multi-channel input conditioner for slow external signals (push buttons, switches, sensor lines). Each channel is synchronised, debounced and edge-detected. Single-cycle rising/falling pulses and sticky, mode-qualified event flags are generated for the control FSMs and the interrupt logic. It sits directly behind the board input pins, ahead of every consumer of asynchronous inputs.

## Interface
Parameters:
- WIDTH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flip-flops per channel (≥2)
- DEBOUNCE_CYCLES, 500000, consecutive cycles a new level must persist before acceptance (≥1); the default is 10 ms at 50 MHz
- RESET_LEVEL, 1'b1, value loaded into the synchroniser and stable level at reset

Ports:
- Reset is rst_n, asynchronous, active-low. The clock is clk50m.
- clk50m  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- in  in  WIDTH  raw asynchronous inputs
- edge_mode  in  2*WIDTH  per-channel qualifier, bits [2i+1:2i], type edge_mode_t
- event_clr  in  WIDTH  per-channel clear of event_pending, synchronous
- level  out  WIDTH  debounced stable level
- risingedge  out  WIDTH  one-cycle pulse when level goes 0→1
- fallingedge  out  WIDTH  one-cycle pulse when level goes 1→0
- event_pending  out  WIDTH  sticky flag, set by a qualified edge
- irq  out  1  OR of all event_pending bits

## Operation
- **Synchroniser:** an SYNC_STAGES-deep FF chain per channel. The last stage is sync[i].
- **Debounce:** each channel has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - sync==level: counter ← 0.
  - sync!=level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync!=level and counter == DEBOUNCE_CYCLES-1: level ← sync, counter ← 0, and the matching pulse register is set for exactly one cycle.
- **Glitch rejection:** a sync glitch shorter than DEBOUNCE_CYCLES cycles resets the counter and produces no level change and no pulse.
- **Raw pulses:** risingedge/fallingedge are independent of edge_mode. They can never both be high on the same channel.
- **edge_mode decoding:**
  - EDGE_OFF=00: no events.
  - EDGE_RISE=01: rising edges only.
  - EDGE_FALL=10: falling edges only.
  - EDGE_BOTH=11: both edges.
- **event_pending[i]:** set on the clock edge following a qualified pulse. It is cleared when event_clr[i]=1.
  - Simultaneous qualified pulse and clear: set wins and the flag stays 1.
  - Changing edge_mode never clears an existing flag. It only gates new sets.
- **irq:** OR of event_pending registers, with no extra logic stage.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels are all recorded.

## Timing
- **Reset values:** every sync stage and level = RESET_LEVEL; counters = 0; risingedge = fallingedge = 0; event_pending = 0; irq = 0.
  - Reset asserted mid-count aborts the count with no pulse.
  - After release, an input equal to RESET_LEVEL produces no edge.
- **Latency:** take an input change stable before clock edge 0. level and the pulse update on edge SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. they are visible SYNC_STAGES+DEBOUNCE_CYCLES cycles after the change. event_pending follows one edge later.
- **Pulse width:** exactly 1 clk50m cycle.
- **Minimum spacing:** two accepted edges on one channel are at least DEBOUNCE_CYCLES cycles apart.
- **Counter bounds:** the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

## Structure
- Package edge_event_pkg holds:
  - typedef enum logic [1:0] edge_mode_t {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}
  - a constant function for the counter width
- Sub-module debounce_channel contains the synchroniser, counter, level and pulse registers for one channel. It is instantiated WIDTH times in a generate loop.
- The top level holds mode qualification, event_pending and irq.

## Test plan
All scenarios use WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- **Reset:** reset with in=4'hF, then release → level=4'hF, no pulses, event_pending=0, irq=0 for 20 cycles.
- **Clean falling edge:** in[0] 1→0 held, mode0=EDGE_FALL → fallingedge[0] high exactly 1 cycle, 6 cycles after the change; event_pending[0]=1 and irq=1 one cycle later.
- **Glitch:** in[1] low for 3 cycles, then high → level[1] stays 1, no pulse, counter returns to 0.
- **Mode gating:** mode2=EDGE_RISE, in[2] 1→0→1, each level held 10 cycles → both raw pulses seen; event_pending[2] set only after the rising edge.
- **Clear vs set:**
  - event_clr[3] asserted in the same cycle as a qualified pulse on channel 3 → flag stays 1.
  - A later lone clear → flag 0, irq 0.
- **Reset mid-count:** rst_n asserted while channel 0 counter=2 → all outputs return to reset values immediately; no pulse after release.
